// File: rtl/framebuffer.sv
// Double-buffered 16-bit framebuffer. GPU writes land in the back bank, scanout reads
// come from the front bank, and a requested swap is deferred to the next vsync rising edge.
module framebuffer #(
  parameter int unsigned FB_WIDTH  = 400,
  parameter int unsigned FB_HEIGHT = 240
) (
  input  logic                         clk,
  input  logic                         reset,
  // GPU write port
  input  logic [$clog2(FB_WIDTH):0]    fb_x,
  input  logic [$clog2(FB_HEIGHT):0]   fb_y,
  input  logic [15:0]                  fb_color,
  input  logic                         fb_write,
  // Scanout read port
  input  logic [$clog2(FB_WIDTH):0]    rd_x,
  input  logic [$clog2(FB_HEIGHT):0]   rd_y,
  input  logic                         rd_en,
  output logic [15:0]                  rd_color,
  output logic                         rd_valid,
  // Swap control
  input  logic                         vsync,
  input  logic                         ctrl_swap,
  output logic                         swap_pending,
  output logic                         front_sel
);

  localparam int unsigned XW    = $clog2(FB_WIDTH) + 1;
  localparam int unsigned YW    = $clog2(FB_HEIGHT) + 1;
  localparam int unsigned Depth = FB_WIDTH * FB_HEIGHT;
  localparam int unsigned AddrW = $clog2(Depth);
  // Wide enough for the largest y*FB_WIDTH+x the coordinate ports can express.
  localparam int unsigned FullW = YW + $clog2(FB_WIDTH) + 1;

  typedef enum logic {StIdle, StPending} state_e;

  state_e state_q, state_d;
  logic   front_sel_q, front_sel_d;
  logic   old_vsync, old_ctrl_swap;
  logic   vsync_edge, swap_req;

  logic [15:0] bank0 [Depth];
  logic [15:0] bank1 [Depth];

  logic [FullW-1:0] wr_lin, rd_lin;
  logic [AddrW-1:0] wr_addr, rd_addr;
  logic             wr_ok, rd_ok;
  logic [15:0]      rd_color_q;
  logic             rd_valid_q;

  // Linear addresses are formed at full width so out-of-range coordinates cannot alias.
  always_comb begin
    wr_lin  = FullW'(fb_y) * FullW'(FB_WIDTH) + FullW'(fb_x);
    rd_lin  = FullW'(rd_y) * FullW'(FB_WIDTH) + FullW'(rd_x);
    wr_addr = wr_lin[AddrW-1:0];
    rd_addr = rd_lin[AddrW-1:0];
    // The linear check is redundant with the coordinate checks but guards the truncation.
    wr_ok   = (fb_x < XW'(FB_WIDTH)) && (fb_y < YW'(FB_HEIGHT)) && (wr_lin < FullW'(Depth));
    rd_ok   = (rd_x < XW'(FB_WIDTH)) && (rd_y < YW'(FB_HEIGHT)) && (rd_lin < FullW'(Depth));
  end

  assign vsync_edge = !old_vsync && vsync;
  assign swap_req   = !old_ctrl_swap && ctrl_swap;

  // Edge-detect history for vsync and the swap request.
  always_ff @(posedge clk) begin
    if (reset) begin
      old_vsync     <= 1'b0;
      old_ctrl_swap <= 1'b0;
    end else begin
      old_vsync     <= vsync;
      old_ctrl_swap <= ctrl_swap;
    end
  end

  // Swap FSM state and front-bank selector.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      front_sel_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      front_sel_q <= front_sel_d;
    end
  end

  // Swap FSM next state: requests wait for a vsync edge; extra requests while pending are absorbed.
  always_comb begin
    state_d     = state_q;
    front_sel_d = front_sel_q;
    unique case (state_q)
      StIdle: begin
        if (swap_req) begin
          if (vsync_edge) begin
            front_sel_d = !front_sel_q;
          end else begin
            state_d = StPending;
          end
        end
      end
      StPending: begin
        if (vsync_edge) begin
          front_sel_d = !front_sel_q;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Back-bank write port; uses the pre-swap selector so a swap-cycle write becomes visible.
  always_ff @(posedge clk) begin
    if (!reset && fb_write && wr_ok) begin
      if (front_sel_q) begin
        bank0[wr_addr] <= fb_color;
      end else begin
        bank1[wr_addr] <= fb_color;
      end
    end
  end

  // Front-bank read port, one cycle latency; out-of-range reads return zero but stay valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid_q <= 1'b0;
      rd_color_q <= 16'h0000;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) begin
        if (!rd_ok) begin
          rd_color_q <= 16'h0000;
        end else if (front_sel_q) begin
          rd_color_q <= bank1[rd_addr];
        end else begin
          rd_color_q <= bank0[rd_addr];
        end
      end
    end
  end

  assign rd_color     = rd_color_q;
  assign rd_valid     = rd_valid_q;
  assign swap_pending = (state_q == StPending);
  assign front_sel    = front_sel_q;

endmodule

// File: tb/tb_framebuffer.sv
// Directed self-checking bench for the double-buffered framebuffer.
module tb_framebuffer;

  localparam int XW = 10;
  localparam int YW = 9;

  logic          clk;
  logic          reset;
  logic [XW-1:0] fb_x;
  logic [YW-1:0] fb_y;
  logic [15:0]   fb_color;
  logic          fb_write;
  logic [XW-1:0] rd_x;
  logic [YW-1:0] rd_y;
  logic          rd_en;
  logic [15:0]   rd_color;
  logic          rd_valid;
  logic          vsync;
  logic          ctrl_swap;
  logic          swap_pending;
  logic          front_sel;

  int tests;
  int fails;

  framebuffer #(
    .FB_WIDTH (400),
    .FB_HEIGHT(240)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .fb_x        (fb_x),
    .fb_y        (fb_y),
    .fb_color    (fb_color),
    .fb_write    (fb_write),
    .rd_x        (rd_x),
    .rd_y        (rd_y),
    .rd_en       (rd_en),
    .rd_color    (rd_color),
    .rd_valid    (rd_valid),
    .vsync       (vsync),
    .ctrl_swap   (ctrl_swap),
    .swap_pending(swap_pending),
    .front_sel   (front_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_px(input int x, input int y, input logic [15:0] c);
    fb_x     = XW'(x);
    fb_y     = YW'(y);
    fb_color = c;
    fb_write = 1'b1;
    tick();
    fb_write = 1'b0;
  endtask

  task automatic read_px(input int x, input int y, output logic [15:0] c, output logic v);
    rd_x  = XW'(x);
    rd_y  = YW'(y);
    rd_en = 1'b1;
    tick();
    c     = rd_color;
    v     = rd_valid;
    rd_en = 1'b0;
  endtask

  task automatic pulse_swap();
    ctrl_swap = 1'b1;
    tick();
    ctrl_swap = 1'b0;
    tick();
  endtask

  task automatic pulse_vsync();
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    logic [15:0] c;
    logic        v;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tests++;
    if (front_sel !== 1'b0) begin
      fails++; $display("FAIL reset_front_sel: got %b want 0", front_sel);
    end
    tests++;
    if (swap_pending !== 1'b0) begin
      fails++; $display("FAIL reset_swap_pending: got %b want 0", swap_pending);
    end
    tests++;
    if (rd_valid !== 1'b0 || rd_color !== 16'h0000) begin
      fails++; $display("FAIL reset_rd: got valid=%b color=%h want 0/0000", rd_valid, rd_color);
    end
    read_px(0, 0, c, v);
    tests++;
    if (v !== 1'b1) begin
      fails++; $display("FAIL reset_first_read_valid: got %b want 1", v);
    end
    tick();
    tests++;
    if (rd_valid !== 1'b0) begin
      fails++; $display("FAIL reset_valid_drops: got %b want 0", rd_valid);
    end
  endtask

  task automatic test_write_swap_read();
    logic [15:0] c;
    logic        v;
    write_px(5, 3, 16'hABCD);
    write_px(399, 239, 16'h1235);
    ctrl_swap = 1'b1;
    tick();
    ctrl_swap = 1'b0;
    tests++;
    if (swap_pending !== 1'b1 || front_sel !== 1'b0) begin
      fails++;
      $display("FAIL wsr_pending: got pending=%b front=%b want 1/0", swap_pending, front_sel);
    end
    tick();
    vsync = 1'b1;
    tick();
    tests++;
    if (front_sel !== 1'b1 || swap_pending !== 1'b0) begin
      fails++;
      $display("FAIL wsr_swapped: got front=%b pending=%b want 1/0", front_sel, swap_pending);
    end
    vsync = 1'b0;
    tick();
    // Back-to-back pipelined reads.
    rd_x = XW'(5); rd_y = YW'(3); rd_en = 1'b1;
    tick();
    tests++;
    if (rd_valid !== 1'b1 || rd_color !== 16'hABCD) begin
      fails++; $display("FAIL wsr_read_5_3: got %b/%h want 1/abcd", rd_valid, rd_color);
    end
    rd_x = XW'(399); rd_y = YW'(239);
    tick();
    rd_en = 1'b0;
    tests++;
    if (rd_valid !== 1'b1 || rd_color !== 16'h1235) begin
      fails++; $display("FAIL wsr_read_399_239: got %b/%h want 1/1235", rd_valid, rd_color);
    end
    tick();
    tests++;
    if (rd_valid !== 1'b0 || rd_color !== 16'h1235) begin
      fails++; $display("FAIL wsr_hold: got %b/%h want 0/1235", rd_valid, rd_color);
    end
    read_px(5, 3, c, v);
    tests++;
    if (v !== 1'b1 || c !== 16'hABCD) begin
      fails++; $display("FAIL wsr_reread: got %b/%h want 1/abcd", v, c);
    end
  endtask

  task automatic test_bounds();
    logic [15:0] c;
    logic        v;
    // Front is bank 1, so these land in bank 0.
    write_px(0, 0, 16'h2222);
    write_px(0, 1, 16'h3333);
    write_px(400, 0, 16'hFFFF);
    write_px(0, 240, 16'hFFFF);
    pulse_swap();
    pulse_vsync();
    tests++;
    if (front_sel !== 1'b0) begin
      fails++; $display("FAIL bounds_front: got %b want 0", front_sel);
    end
    read_px(0, 0, c, v);
    tests++;
    if (v !== 1'b1 || c !== 16'h2222) begin
      fails++; $display("FAIL bounds_0_0: got %b/%h want 1/2222", v, c);
    end
    read_px(0, 1, c, v);
    tests++;
    if (v !== 1'b1 || c !== 16'h3333) begin
      fails++; $display("FAIL bounds_0_1: got %b/%h want 1/3333", v, c);
    end
    read_px(400, 10, c, v);
    tests++;
    if (v !== 1'b1 || c !== 16'h0000) begin
      fails++; $display("FAIL bounds_oob_read: got %b/%h want 1/0000", v, c);
    end
  endtask

  task automatic test_deferred_absorbed();
    pulse_swap();
    tests++;
    if (swap_pending !== 1'b1 || front_sel !== 1'b0) begin
      fails++;
      $display("FAIL defer_first: got pending=%b front=%b want 1/0", swap_pending, front_sel);
    end
    pulse_swap();
    tests++;
    if (swap_pending !== 1'b1 || front_sel !== 1'b0) begin
      fails++;
      $display("FAIL defer_second: got pending=%b front=%b want 1/0", swap_pending, front_sel);
    end
    vsync = 1'b1;
    tick();
    tests++;
    if (front_sel !== 1'b1 || swap_pending !== 1'b0) begin
      fails++;
      $display("FAIL defer_once: got front=%b pending=%b want 1/0", front_sel, swap_pending);
    end
    vsync = 1'b0;
    tick();
    pulse_vsync();
    tests++;
    if (front_sel !== 1'b1 || swap_pending !== 1'b0) begin
      fails++;
      $display("FAIL defer_no_req: got front=%b pending=%b want 1/0", front_sel, swap_pending);
    end
  endtask

  task automatic test_simultaneous();
    logic [15:0] c;
    logic        v;
    // Front is bank 1 (holds abcd at 5,3); swap, write and read all in one cycle.
    ctrl_swap = 1'b1;
    vsync     = 1'b1;
    fb_x = XW'(7); fb_y = YW'(7); fb_color = 16'h0F0F; fb_write = 1'b1;
    rd_x = XW'(5); rd_y = YW'(3); rd_en = 1'b1;
    tick();
    ctrl_swap = 1'b0;
    vsync     = 1'b0;
    fb_write  = 1'b0;
    rd_en     = 1'b0;
    tests++;
    if (front_sel !== 1'b0 || swap_pending !== 1'b0) begin
      fails++;
      $display("FAIL simul_swap: got front=%b pending=%b want 0/0", front_sel, swap_pending);
    end
    tests++;
    if (rd_valid !== 1'b1 || rd_color !== 16'hABCD) begin
      fails++; $display("FAIL simul_old_front_read: got %b/%h want 1/abcd", rd_valid, rd_color);
    end
    tick();
    tests++;
    if (swap_pending !== 1'b0 || front_sel !== 1'b0) begin
      fails++;
      $display("FAIL simul_after: got pending=%b front=%b want 0/0", swap_pending, front_sel);
    end
    read_px(7, 7, c, v);
    tests++;
    if (v !== 1'b1 || c !== 16'h0F0F) begin
      fails++; $display("FAIL simul_write_visible: got %b/%h want 1/0f0f", v, c);
    end
  endtask

  task automatic test_vsync_held();
    vsync = 1'b1;
    tick();
    tests++;
    if (front_sel !== 1'b0) begin
      fails++; $display("FAIL held_no_req: got front=%b want 0", front_sel);
    end
    pulse_swap();
    tick();
    tick();
    tests++;
    if (swap_pending !== 1'b1 || front_sel !== 1'b0) begin
      fails++;
      $display("FAIL held_waits: got pending=%b front=%b want 1/0", swap_pending, front_sel);
    end
    vsync = 1'b0;
    tick();
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    tests++;
    if (front_sel !== 1'b1 || swap_pending !== 1'b0) begin
      fails++;
      $display("FAIL held_new_edge: got front=%b pending=%b want 1/0", front_sel, swap_pending);
    end
    tick();
  endtask

  task automatic test_reset_mid_pending();
    logic [15:0] c;
    logic        v;
    // Front is bank 1; a request is pending when reset hits along with a write and a read.
    pulse_swap();
    tests++;
    if (swap_pending !== 1'b1) begin
      fails++; $display("FAIL rst_mid_pending_set: got %b want 1", swap_pending);
    end
    reset = 1'b1;
    fb_x = XW'(7); fb_y = YW'(7); fb_color = 16'hBEEF; fb_write = 1'b1;
    rd_x = XW'(5); rd_y = YW'(3); rd_en = 1'b1;
    tick();
    reset    = 1'b0;
    fb_write = 1'b0;
    rd_en    = 1'b0;
    tests++;
    if (front_sel !== 1'b0 || swap_pending !== 1'b0 || rd_valid !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid_state: got front=%b pending=%b valid=%b want 0/0/0",
               front_sel, swap_pending, rd_valid);
    end
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    tests++;
    if (front_sel !== 1'b0 || swap_pending !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid_lost: got front=%b pending=%b want 0/0", front_sel, swap_pending);
    end
    tick();
    read_px(7, 7, c, v);
    tests++;
    if (v !== 1'b1 || c !== 16'h0F0F) begin
      fails++; $display("FAIL rst_mid_write_ignored: got %b/%h want 1/0f0f", v, c);
    end
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    reset     = 1'b1;
    fb_x      = '0;
    fb_y      = '0;
    fb_color  = '0;
    fb_write  = 1'b0;
    rd_x      = '0;
    rd_y      = '0;
    rd_en     = 1'b0;
    vsync     = 1'b0;
    ctrl_swap = 1'b0;
    #2;
    test_reset();
    test_write_swap_read();
    test_bounds();
    test_deferred_absorbed();
    test_simultaneous();
    test_vsync_held();
    test_reset_mid_pending();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
